gtfwizard_mac_gtf_common_drp_master: RTL and testbench

- DRP initiator that drives the DRP port of the GTF common tile wrapper (drpen/drpwe/drpaddr/drpdi out; drpdo/drprdy in).
- Accepts single read, write or read-modify-write (RMW) requests from control logic, e.g. QPLL FBDIV/SDM reprogramming.
- Returns one response per request and enforces one outstanding DRP transaction.
- Guards against a hung tile with a drprdy timeout.

---
 rtl/gtfwizard_mac_drp_pkg.sv | 20 ++
 rtl/gtfwizard_mac_drp_timeout_cnt.sv | 30 +++
 rtl/gtfwizard_mac_gtf_common_drp_master.sv | 124 ++++++++++++
 tb/tb_gtfwizard_mac_gtf_common_drp_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gtfwizard_mac_drp_pkg.sv
// Shared encodings for the GTF common DRP master: request opcodes,
// FSM states and the default drprdy timeout.
package gtfwizard_mac_drp_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  localparam int TIMEOUT_CYCLES_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    RESP
  } drp_state_e;

endpackage

// File: rtl/gtfwizard_mac_drp_timeout_cnt.sv
// drprdy watchdog: counts cycles spent waiting, flags expiry at
// TIMEOUT_CYCLES-1 and holds there until cleared.
module gtfwizard_mac_drp_timeout_cnt
  import gtfwizard_mac_drp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gtfwizard_mac_gtf_common_drp_master.sv
// Single-outstanding DRP initiator for the GTF common tile: READ, WRITE and
// read-modify-write requests, one response each, with a drprdy timeout.
module gtfwizard_mac_gtf_common_drp_master
  import gtfwizard_mac_drp_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              gtf_cm_drpclk,
  input  logic              gtf_cm_drprst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic              drp_en,
  output logic              drp_we,
  output logic [ADDR_W-1:0] drp_addr,
  output logic [DATA_W-1:0] drp_di,
  input  logic [DATA_W-1:0] drp_do,
  input  logic              drp_rdy
);

  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rd,
                                                  input logic [DATA_W-1:0] wd,
                                                  input logic [DATA_W-1:0] mask);
    return (rd & ~mask) | (wd & mask);
  endfunction

  drp_state_e        state, state_n;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] rd_q;
  logic              wait_st;
  logic              expire;
  logic              timeout;
  logic              accept;
  logic              issue_n;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && req_valid;
  assign wait_st   = (state == RD_WAIT) || (state == WR_WAIT);
  // drprdy in the expiry cycle still counts as a normal completion
  assign timeout   = wait_st && !drp_rdy && expire;
  assign issue_n   = (state_n == RD_ISSUE) || (state_n == WR_ISSUE);

  gtfwizard_mac_drp_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (gtf_cm_drpclk),
    .rst_n (gtf_cm_drprst_n),
    .clear (!wait_st),
    .enable(wait_st),
    .expire(expire)
  );

  always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_drprst_n) begin
    if (!gtf_cm_drprst_n) state <= IDLE;
    else                  state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (req_valid) state_n = (req_op == OP_WRITE) ? WR_ISSUE : RD_ISSUE;
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT: begin
        if (drp_rdy)      state_n = (op_q == OP_RMW) ? WR_ISSUE : RESP;
        else if (expire)  state_n = RESP;
      end
      WR_ISSUE: state_n = WR_WAIT;
      WR_WAIT:  if (drp_rdy || expire) state_n = RESP;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_drprst_n) begin
    if (!gtf_cm_drprst_n) begin
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      rd_q      <= '0;
      drp_en    <= 1'b0;
      drp_we    <= 1'b0;
      drp_addr  <= '0;
      drp_di    <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mask_q  <= req_mask;
      end
      if (state == RD_WAIT && drp_rdy) rd_q <= drp_do;
      drp_en <= issue_n;
      drp_we <= (state_n == WR_ISSUE);
      if (issue_n) drp_addr <= (state == IDLE) ? req_addr : addr_q;
      if (state_n == WR_ISSUE)
        drp_di <= (state == IDLE) ? req_wdata : rmw_merge(drp_do, wdata_q, mask_q);
      rsp_valid <= (state_n == RESP);
      rsp_error <= timeout;
      if (state_n == RESP && !timeout && op_q != OP_WRITE)
        rsp_rdata <= (state == RD_WAIT) ? drp_do : rd_q;
      else
        rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_gtfwizard_mac_gtf_common_drp_master.sv
// Directed bench for the GTF common DRP master with a behavioural DRP
// responder that answers each drp_en after a programmable delay.
module tb_gtfwizard_mac_gtf_common_drp_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] req_mask = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        drp_en;
  logic        drp_we;
  logic [15:0] drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_rdy;

  logic        auto_rdy = 1'b0;
  logic        manual_rdy = 1'b0;
  logic [15:0] do_val = '0;
  int          resp_n = 0;
  int          fire_cyc = -100;
  int          cyc = 0;
  int          en_count = 0;
  logic        last_we = 1'b0;
  logic [15:0] last_addr = '0;
  logic [15:0] last_di = '0;
  int          tests = 0;
  int          fails = 0;

  assign drp_rdy = auto_rdy | manual_rdy;
  assign drp_do  = drp_rdy ? do_val : 16'h5A5A;

  gtfwizard_mac_gtf_common_drp_master #(
    .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .gtf_cm_drpclk  (clk),
    .gtf_cm_drprst_n(rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_mask       (req_mask),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .busy           (busy),
    .drp_en         (drp_en),
    .drp_we         (drp_we),
    .drp_addr       (drp_addr),
    .drp_di         (drp_di),
    .drp_do         (drp_do),
    .drp_rdy        (drp_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: rdy is driven for the single cycle N cycles after drp_en
  always @(negedge clk) begin
    if (drp_en) begin
      en_count  = en_count + 1;
      last_we   = drp_we;
      last_addr = drp_addr;
      last_di   = drp_di;
      fire_cyc  = cyc + resp_n;
    end
    auto_rdy = (resp_n != 0) && (cyc == fire_cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] mask,
                         input int n, input logic [15:0] rdv,
                         output int lat, output logic [15:0] rdata, output logic err);
    int start;
    lat = -1; rdata = 16'hxxxx; err = 1'bx;
    @(negedge clk);
    resp_n = n; do_val = rdv; en_count = 0;
    req_op = op; req_addr = addr; req_wdata = wdata; req_mask = mask;
    req_valid = 1'b1;
    start = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - start; rdata = rsp_rdata; err = rsp_error;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mask;
    int          n;
    logic [15:0] rdv;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    logic        exp_we;
    logic [15:0] exp_di;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          lat;
    logic [15:0] rdata;
    logic        err;
    logic        quiet;
    int          rsp1, rsp2, rdy2;
    logic [15:0] r1, r2;

    // n = 0: the responder never raises drp_rdy
    tbl[0] = '{2'b00, 16'h0014, 16'h0000, 16'h0000, 3, 16'h1C39, 16'h1C39, 1'b0, 5,  1, 1'b0, 16'h0000};
    tbl[1] = '{2'b01, 16'h0008, 16'hA5A5, 16'h0000, 1, 16'h0000, 16'h0000, 1'b0, 3,  1, 1'b1, 16'hA5A5};
    tbl[2] = '{2'b10, 16'h0014, 16'h00F0, 16'h0FF0, 2, 16'hFF00, 16'hFF00, 1'b0, 7,  2, 1'b1, 16'hF0F0};
    tbl[3] = '{2'b10, 16'h0014, 16'h00F0, 16'h0FF0, 0, 16'hFF00, 16'h0000, 1'b1, 10, 1, 1'b0, 16'h0000};
    tbl[4] = '{2'b10, 16'h0020, 16'hFFFF, 16'h00FF, 8, 16'h1234, 16'h1234, 1'b0, 19, 2, 1'b1, 16'h12FF};
    tbl[5] = '{2'b11, 16'h0030, 16'h9999, 16'hFFFF, 2, 16'hBEEF, 16'hBEEF, 1'b0, 4,  1, 1'b0, 16'h0000};
    tbl[6] = '{2'b01, 16'h000C, 16'h1111, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1, 10, 1, 1'b1, 16'h1111};
    tbl[7] = '{2'b00, 16'h0002, 16'h0000, 16'h0000, 7, 16'h0042, 16'h0042, 1'b0, 9,  1, 1'b0, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {26'd0, req_ready, busy, rsp_valid, rsp_error, drp_en, drp_we}, 32'b100000);
    check("reset_data", {drp_addr, drp_di}, 32'h0);
    check("reset_rdata", {16'd0, rsp_rdata}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].n, tbl[i].rdv, lat, rdata, err);
      check($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
      check($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, tbl[i].exp_rdata});
      check($sformatf("v%0d_error", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
      check($sformatf("v%0d_en_cycles", i), en_count, tbl[i].exp_en);
      check($sformatf("v%0d_last_we", i), {31'd0, last_we}, {31'd0, tbl[i].exp_we});
      check($sformatf("v%0d_addr", i), {16'd0, last_addr}, {16'd0, tbl[i].addr});
      if (tbl[i].exp_we) check($sformatf("v%0d_di", i), {16'd0, last_di}, {16'd0, tbl[i].exp_di});
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {30'd0, rsp_valid, req_ready}, 32'b01);
    end

    // Timeout on RMW, then a stray late drp_rdy must change nothing
    run_txn(2'b10, 16'h0014, 16'h00F0, 16'h0FF0, 0, 16'hFF00, lat, rdata, err);
    check("tmo_latency", lat, 10);
    check("tmo_error", {31'd0, err}, 32'd1);
    check("tmo_no_write", en_count, 1);
    repeat (2) @(negedge clk);
    manual_rdy = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      manual_rdy = 1'b0;
      if (rsp_valid || rsp_error || drp_en || busy || rsp_rdata != 16'h0) quiet = 1'b0;
    end
    check("stray_rdy_ignored", {31'd0, quiet}, 32'd1);
    check("stray_rdy_no_en", en_count, 1);

    // Reset in the middle of RD_WAIT
    @(negedge clk);
    resp_n = 0; en_count = 0;
    req_op = 2'b00; req_addr = 16'h0044; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {26'd0, req_ready, busy, rsp_valid, rsp_error, drp_en, drp_we}, 32'b100000);
    check("mid_rst_data", {drp_addr, drp_di}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_val = 16'h1357;
    manual_rdy = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      manual_rdy = 1'b0;
      if (rsp_valid || busy) quiet = 1'b0;
    end
    check("post_rst_no_rsp", {31'd0, quiet}, 32'd1);
    run_txn(2'b00, 16'h0046, 16'h0, 16'h0, 2, 16'h7777, lat, rdata, err);
    check("post_rst_latency", lat, 4);
    check("post_rst_rdata", {16'd0, rdata}, 32'h7777);

    // req_valid held while busy; second request (op 11) taken after RESP
    @(negedge clk);
    resp_n = 3; do_val = 16'hAAAA; en_count = 0;
    req_op = 2'b00; req_addr = 16'h0010; req_valid = 1'b1;
    rsp1 = -1; rsp2 = -1; rdy2 = -1; r1 = '0; r2 = '0;
    @(posedge clk);
    #1 req_op = 2'b11; req_addr = 16'h0020;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp1 < 0) begin
        rsp1 = k; r1 = rsp_rdata;
      end else if (rsp_valid) begin
        rsp2 = k; r2 = rsp_rdata;
        break;
      end
      if (req_ready && rdy2 < 0) begin
        rdy2 = k; do_val = 16'hBBBB;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("held_rsp1_cycle", rsp1, 5);
    check("held_ready_cycle", rdy2, 6);
    check("held_rsp2_cycle", rsp2, 11);
    check("held_rdata1", {16'd0, r1}, 32'hAAAA);
    check("held_rdata2", {16'd0, r2}, 32'hBBBB);
    check("held_en_cycles", en_count, 2);
    check("op11_we", {31'd0, last_we}, 32'd0);
    check("op11_addr", {16'd0, last_addr}, 32'h0020);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
